// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uart_rx -- UART receiver, 8 data bits, LSB first, one stop bit.
//
// The line is oversampled OVERSAMPLE times per bit by an internal tick divider
// (DIV = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE) clocks per tick). The start bit
// is confirmed at its middle, then every following bit is sampled one bit
// period later, so all samples land mid-bit. Received bytes are offered on a
// valid/read handshake.
//
// Optional feature (macro UART_RX_PARITY_EN): adds a parity bit between the
// data and the stop bit (even when PARITY_ODD=0, odd when PARITY_ODD=1) and
// the parity_err port. Without the macro the frame is 8N1.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   rx         in   serial line, asynchronous, idles high
//   rx_read    in   consumer pulse: byte in rx_data has been taken
//   rx_data    out  last received byte
//   rx_valid   out  rx_data holds an unread byte
//   rx_busy    out  a frame is being received
//   frame_err  out  1-cycle pulse: stop bit sampled low
//   overrun    out  1-cycle pulse: new byte replaced an unread byte
//   parity_err out  1-cycle pulse with the byte update: parity mismatch
//                   (present only with UART_RX_PARITY_EN)
//
// Handshake: rx_valid rises when a byte completes and stays high until a
// cycle with rx_read=1; it clears on the following edge. rx_read while
// rx_valid=0 has no effect. A byte completing in the same cycle as rx_read
// replaces the consumed one cleanly (rx_valid stays 1, no overrun).
// -----------------------------------------------------------------------------
module uart_rx #(
    parameter int CLOCK_FREQ = 50000000,
    parameter int BAUD_RATE  = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       rx_read,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       overrun
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parity_err
`endif
);

    localparam int DIV    = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TICK_W = $clog2(OVERSAMPLE);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(OVERSAMPLE / 2 - 1);

    localparam bit CFG_OK = (OVERSAMPLE >= 8) && (OVERSAMPLE % 2 == 0) &&
                            (DIV >= 1) && (PARITY_ODD == 0 || PARITY_ODD == 1);

    generate
        if (!CFG_OK) begin : g_bad_cfg
            $error("uart_rx: OVERSAMPLE must be even and >= 8, DIV >= 1, PARITY_ODD 0 or 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    state_t              state, state_next;
    logic                rx_meta, rxs, rxs_d;
    logic [DIV_W-1:0]    div_cnt;
    logic [TICK_W-1:0]   tick_cnt;
    logic [2:0]          bit_cnt;
    logic [7:0]          shreg;
    logic                tick, half_pt, bit_end;
    logic                cnt_clr, shift_en, deliver, stop_bad;
`ifdef UART_RX_PARITY_EN
    localparam logic PAR_ODD = (PARITY_ODD != 0);
    logic                par_sample, par_bad;
`endif

    assign tick    = (div_cnt == DIV_LAST);
    assign half_pt = tick && (tick_cnt == TICK_HALF);
    assign bit_end = tick && (tick_cnt == TICK_LAST);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // Next state and per-cycle control strobes
    always_comb begin
        state_next = state;
        cnt_clr    = 1'b0;
        shift_en   = 1'b0;
        deliver    = 1'b0;
        stop_bad   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_sample = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (rxs_d && !rxs) begin
                    state_next = S_START;
                    cnt_clr    = 1'b1;
                end
            end
            S_START: begin
                // Start bit still low at its middle: real frame, re-phase the
                // tick counter so later samples are one full bit apart.
                if (half_pt) begin
                    cnt_clr    = 1'b1;
                    state_next = rxs ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_en = 1'b1;
                    if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_next = S_PARITY;
`else
                        state_next = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    par_sample = 1'b1;
                    state_next = S_STOP;
                end
            end
`endif
            S_STOP: begin
                // Leaves mid-stop-bit so a back-to-back start edge is caught.
                if (bit_end) begin
                    if (rxs) begin
                        deliver    = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        stop_bad   = 1'b1;
                        state_next = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                // Held-low line: one frame_err, then wait for the line to idle.
                if (rxs) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Synchroniser, counters and shift register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta  <= 1'b1;
            rxs      <= 1'b1;
            rxs_d    <= 1'b1;
            div_cnt  <= '0;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
            rxs_d   <= rxs;

            if (cnt_clr || tick) div_cnt <= '0;
            else                 div_cnt <= div_cnt + 1'b1;

            if (cnt_clr)                      tick_cnt <= '0;
            else if (tick && tick_cnt == TICK_LAST) tick_cnt <= '0;
            else if (tick)                    tick_cnt <= tick_cnt + 1'b1;

            if (cnt_clr)       bit_cnt <= '0;
            else if (shift_en) bit_cnt <= bit_cnt + 1'b1;

            if (shift_en) shreg <= {rxs, shreg[7:1]};
        end
    end

`ifdef UART_RX_PARITY_EN
    // Mismatch is held until the stop bit so parity_err aligns with the byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (par_sample) par_bad <= rxs ^ (^shreg) ^ PAR_ODD;
            parity_err <= deliver && par_bad;
        end
    end
`endif

    // Output register and handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            rx_busy   <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            rx_busy   <= (state_next != S_IDLE) && (state_next != S_BREAK);
            frame_err <= stop_bad;
            overrun   <= deliver && rx_valid && !rx_read;
            if (deliver) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
            end else if (rx_read) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int CLOCK_FREQ = 1600000;
  localparam int BAUD_RATE  = 100000;
  localparam int OVERSAMPLE = 16;
  localparam int PARITY_ODD = 0;
  localparam int BIT_CLKS   = CLOCK_FREQ / BAUD_RATE;
`ifdef UART_RX_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif
  // Clocks from the start-bit drive to the completion edge: 2 sync + half bit
  // + 8 data bits (+ parity) + stop bit, plus one for the synchroniser input.
  localparam int DONE_CLKS = 1 + 2 + BIT_CLKS / 2 + 8 * BIT_CLKS
                             + (PARITY_EN ? BIT_CLKS : 0) + BIT_CLKS - 2;
  localparam logic [1:0] K_BYTE = 2'd1;
  localparam logic [1:0] K_FERR = 2'd2;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       rx_read = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, rx_busy, frame_err, overrun;
  logic       parity_err;

  always #5 clk = ~clk;

  uart_rx #(
    .CLOCK_FREQ(CLOCK_FREQ), .BAUD_RATE(BAUD_RATE),
    .OVERSAMPLE(OVERSAMPLE), .PARITY_ODD(PARITY_ODD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .rx_read(rx_read),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_busy(rx_busy),
    .frame_err(frame_err), .overrun(overrun)
`ifdef UART_RX_PARITY_EN
    , .parity_err(parity_err)
`endif
  );
`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_fail = 0;
  logic [11:0] exp_q[$];    // {kind[1:0], perr, ovr, data[7:0]}
  logic        auto_read = 1'b0;
  logic        manual_read = 1'b0;
  logic        model_valid = 1'b0;  // model: an unread byte is pending

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  function automatic logic par_of(input logic [7:0] d);
    return (^d) ^ (PARITY_ODD != 0);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bits(input logic v, input int n);
    rx = v;
    wait_clks(n);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_bit, input logic stop_bit);
    drive_bits(1'b0, BIT_CLKS);
    for (int i = 0; i < 8; i++) drive_bits(d[i], BIT_CLKS);
    if (PARITY_EN) drive_bits(par_bit, BIT_CLKS);
    drive_bits(stop_bit, BIT_CLKS);
  endtask

  // Sends a well-formed frame and records what the consumer should see.
  task automatic send_good(input logic [7:0] d, input logic par_ok, input logic read_on_done);
    logic perr, ovr, pbit;
    perr = PARITY_EN && !par_ok;
    pbit = par_ok ? par_of(d) : ~par_of(d);
    ovr  = model_valid && !auto_read && !read_on_done;
    exp_q.push_back({K_BYTE, perr, ovr, d});
    model_valid = !auto_read;
    if (read_on_done) begin
      fork
        send_frame(d, pbit, 1'b1);
        begin
          wait_clks(DONE_CLKS - 1);
          manual_read = 1'b1;
          wait_clks(1);
          manual_read = 1'b0;
        end
      join
    end else begin
      send_frame(d, pbit, 1'b1);
    end
  endtask

  task automatic do_read();
    manual_read = 1'b1;
    wait_clks(1);
    manual_read = 1'b0;
    model_valid = 1'b0;
  endtask

  // Consumer: the only process that drives rx_read.
  always begin
    @(posedge clk);
    #2;
    rx_read = manual_read || (auto_read && rx_valid && !rx_read);
  end

  // ---------------- monitor ----------------
  logic        valid_prev = 1'b0;
  logic        read_prev = 1'b0;
  logic        byte_ev;
  logic [11:0] mon_e;

  always @(negedge clk) begin
    if (rst_n) begin
      byte_ev = (rx_valid && !valid_prev) || overrun || (rx_valid && valid_prev && read_prev);
      if (byte_ev) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_byte: got 0x%0h, expected no delivery (t=%0t)", rx_data, $time);
        end else begin
          mon_e = exp_q.pop_front();
          check("byte_kind", 32'(K_BYTE), 32'(mon_e[11:10]));
          check("byte_data", 32'(rx_data), 32'(mon_e[7:0]));
          check("byte_overrun", 32'(overrun), 32'(mon_e[8]));
`ifdef UART_RX_PARITY_EN
          check("byte_parity_err", 32'(parity_err), 32'(mon_e[9]));
`endif
        end
      end
      if (frame_err) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_frame_err: got 1, expected 0 (t=%0t)", $time);
        end else begin
          mon_e = exp_q.pop_front();
          check("ferr_kind", 32'(K_FERR), 32'(mon_e[11:10]));
        end
      end
`ifdef UART_RX_PARITY_EN
      if (parity_err) check("perr_with_byte", 32'(byte_ev), 32'd1);
`endif
    end
    valid_prev = rx_valid;
    read_prev  = rx_read;
  end

  // ---------------- watchdog ----------------
  initial begin
    #5_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] d;
    logic       p_ok;

    #12;
    check("rst_data", 32'(rx_data), 32'h0);
    check("rst_valid", 32'(rx_valid), 32'h0);
    check("rst_busy", 32'(rx_busy), 32'h0);
    check("rst_ferr", 32'(frame_err), 32'h0);
    check("rst_ovr", 32'(overrun), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_clks(5);

    // 1: single byte, no read
    send_good(8'hA5, 1'b1, 1'b0);
    wait_clks(20);
    check("t1_valid", 32'(rx_valid), 32'h1);
    check("t1_data", 32'(rx_data), 32'hA5);
    check("t1_busy", 32'(rx_busy), 32'h0);
    do_read();
    wait_clks(2);
    check("t1_read_clears", 32'(rx_valid), 32'h0);

    // 2: back-to-back without read (overrun), then read on completion cycle
    send_good(8'h3C, 1'b1, 1'b0);
    send_good(8'h81, 1'b1, 1'b0);
    wait_clks(20);
    check("t2_data", 32'(rx_data), 32'h81);
    check("t2_valid", 32'(rx_valid), 32'h1);
    do_read();
    send_good(8'h3C, 1'b1, 1'b0);
    send_good(8'h81, 1'b1, 1'b1);
    wait_clks(20);
    check("t2b_valid", 32'(rx_valid), 32'h1);
    check("t2b_data", 32'(rx_data), 32'h81);
    do_read();
    wait_clks(2);

    // 3: 5-clock glitch
    drive_bits(1'b0, 5);
    check("t3_busy_on", 32'(rx_busy), 32'h1);
    drive_bits(1'b1, 30);
    check("t3_busy_off", 32'(rx_busy), 32'h0);
    check("t3_valid", 32'(rx_valid), 32'h0);

    // 4: stop bit low, line held low 40 bit times
    exp_q.push_back({K_FERR, 1'b0, 1'b0, 8'h00});
    send_frame(8'h55, par_of(8'h55), 1'b0);
    drive_bits(1'b0, 40 * BIT_CLKS);
    check("t4_busy_break", 32'(rx_busy), 32'h0);
    drive_bits(1'b1, 3 * BIT_CLKS);
    check("t4_valid", 32'(rx_valid), 32'h0);
    auto_read = 1'b1;
    send_good(8'h12, 1'b1, 1'b0);
    wait_clks(20);

    // 5: asynchronous reset in data bit 4 of 0xFF
    fork
      send_frame(8'hFF, par_of(8'hFF), 1'b1);
      begin
        wait_clks(5 * BIT_CLKS + 8);
        check("t5_busy_before", 32'(rx_busy), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_data", 32'(rx_data), 32'h0);
        check("t5_rst_busy", 32'(rx_busy), 32'h0);
        check("t5_rst_valid", 32'(rx_valid), 32'h0);
        wait_clks(3);
        rst_n = 1'b1;
      end
    join
    model_valid = 1'b0;
    wait_clks(10);
    check("t5_idle_after", 32'(rx_valid), 32'h0);
    send_good(8'h0F, 1'b1, 1'b0);
    wait_clks(20);

    // 6: parity good / bad
    if (PARITY_EN) begin
      send_good(8'h07, 1'b1, 1'b0);
      send_good(8'h07, 1'b0, 1'b0);
      wait_clks(20);
    end

    // Randomised traffic: random bytes, gaps, read policy and parity errors
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        auto_read = 1'b0;
      end else begin
        auto_read = 1'b1;
        model_valid = 1'b0;
      end
      wait_clks(3);
      d    = 8'($urandom_range(0, 255));
      p_ok = PARITY_EN ? ($urandom_range(0, 3) != 0) : 1'b1;
      send_good(d, p_ok, 1'b0);
      drive_bits(1'b1, $urandom_range(0, 20));
    end
    auto_read = 1'b1;
    wait_clks(40);
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    check("final_valid", 32'(rx_valid), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
